// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeds a start/data/parity/stop serialiser.
// Queued words are sent back-to-back, LSB first, on uart_txd.
module uart_tx_fifo #(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0]           uart_tx_data,
  output logic                              uart_tx_ready,
  output logic                              uart_tx_busy,
  output logic                              uart_tx_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              uart_txd
);

  localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int unsigned STOP_CYCLES    = CYCLES_PER_BIT * STOP_BITS;
  localparam int unsigned CNT_W          = $clog2(STOP_CYCLES + 1);
  localparam int unsigned BIT_W          = $clog2(PAYLOAD_BITS);
  localparam int unsigned PTR_W          = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W          = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    txd_d;
  logic                    pop;
  logic                    push_ok;
  logic                    bit_end;
  logic                    stop_end;

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PAYLOAD_BITS-1:0] head;
  logic                    head_par;

  assign uart_tx_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign uart_tx_busy  = (state_q != S_IDLE) || (fifo_level != '0);
  assign push_ok       = uart_tx_en && uart_tx_ready;

  assign head     = mem[rd_ptr];
  assign head_par = (PARITY == 2) ? ^head : ~^head;
  assign bit_end  = (cnt_q == CNT_W'(CYCLES_PER_BIT - 1));
  assign stop_end = (cnt_q == CNT_W'(STOP_CYCLES - 1));

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= uart_tx_data;
    end
  end

  // State, shifter and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      bit_q            <= '0;
      shift_q          <= '0;
      par_q            <= 1'b0;
      uart_txd         <= 1'b1;
      fifo_level       <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      uart_tx_overflow <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bit_q            <= bit_d;
      shift_q          <= shift_d;
      par_q            <= par_d;
      uart_txd         <= txd_d;
      uart_tx_overflow <= uart_tx_en && !uart_tx_ready;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Next state; txd follows the current state, so the line lags the FSM by one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fifo_level != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(PAYLOAD_BITS - 1)) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        txd_d = par_q;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (stop_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more words are queued
          if (fifo_level != '0) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = head_par;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three configurations at 16 cycles/bit,
// frames decoded off uart_txd and compared against words queued at push time.
module tb_uart_tx_fifo;

  localparam int unsigned CPB        = 16;
  localparam int unsigned RX_TIMEOUT = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       en0, en1, en2;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic [2:0] txd, busy, ready, ovf;
  logic [2:0] lvl0, lvl1;
  logic [1:0] lvl2;

  logic [8:0] exp_q [$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  // 8N1, depth 4
  uart_tx_fifo #(.BIT_RATE(1), .CLK_HZ(16), .PAYLOAD_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .uart_tx_en(en0), .uart_tx_data(d0),
    .uart_tx_ready(ready[0]), .uart_tx_busy(busy[0]), .uart_tx_overflow(ovf[0]),
    .fifo_level(lvl0), .uart_txd(txd[0]));

  // 8E2, depth 4
  uart_tx_fifo #(.BIT_RATE(1), .CLK_HZ(16), .PAYLOAD_BITS(8), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .uart_tx_en(en1), .uart_tx_data(d1),
    .uart_tx_ready(ready[1]), .uart_tx_busy(busy[1]), .uart_tx_overflow(ovf[1]),
    .fifo_level(lvl1), .uart_txd(txd[1]));

  // 5O1, depth 2
  uart_tx_fifo #(.BIT_RATE(1), .CLK_HZ(16), .PAYLOAD_BITS(5), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .uart_tx_en(en2), .uart_tx_data(d2),
    .uart_tx_ready(ready[2]), .uart_tx_busy(busy[2]), .uart_tx_overflow(ovf[2]),
    .fifo_level(lvl2), .uart_txd(txd[2]));

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one push cycle; the word enters the scoreboard only if it should be accepted
  task automatic push(input int idx, input logic [8:0] d, input bit acc);
    case (idx)
      0:       begin en0 = 1'b1; d0 = d[7:0]; end
      1:       begin en1 = 1'b1; d1 = d[7:0]; end
      default: begin en2 = 1'b1; d2 = d[4:0]; end
    endcase
    if (acc) exp_q.push_back((idx == 2) ? (d & 9'h01F) : (d & 9'h0FF));
    @(negedge clk);
    en0 = 1'b0;
    en1 = 1'b0;
    en2 = 1'b0;
  endtask

  task automatic sample_bits(input int idx, input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (txd[idx]) ones++;
    end
  endtask

  // Decode one frame; every bit must hold its level for its whole bit time
  task automatic rx_frame(input int idx, input int pb, input int par, input int sb,
                          input bit b2b);
    int         ones;
    int         waited;
    logic [8:0] w;
    logic [8:0] exp_w;
    logic       exp_p;
    if (b2b) begin
      @(negedge clk);
      check("b2b_start", 32'(txd[idx]), 0);
    end else begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (txd[idx] == 1'b1 && waited < RX_TIMEOUT);
      if (txd[idx] == 1'b1) begin
        check("rx_timeout", 1, 0);
        return;
      end
    end
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
      exp_w = '0;
    end else begin
      exp_w = exp_q.pop_front();
    end
    sample_bits(idx, CPB - 1, ones);
    check("start_bit", 32'(ones), 0);
    w = '0;
    for (int i = 0; i < pb; i++) begin
      sample_bits(idx, CPB, ones);
      w[i] = (ones > CPB / 2);
      check("data_bit", 32'(ones), exp_w[i] ? CPB : 0);
    end
    check("data_word", 32'(w), 32'(exp_w));
    if (par != 0) begin
      exp_p = (par == 2) ? ^exp_w : ~^exp_w;
      sample_bits(idx, CPB, ones);
      check("parity_bit", 32'(ones), exp_p ? CPB : 0);
    end
    sample_bits(idx, sb * CPB, ones);
    check("stop_bits", 32'(ones), 32'(sb) * CPB);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int         bcnt;
    logic [8:0] ow [6];
    ow = '{9'h03C, 9'h0A5, 9'h00F, 9'h0F0, 9'h081, 9'h07E};
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 3'b111);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 3'b111);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_level", 32'(lvl0), 0);
    reset = 1'b0;
    @(negedge clk);

    // 8N1 latency and frame: push at edge N, pop at N+1, start bit from N+2
    push(0, 9'h055, 1'b1);
    check("lat_level_n", 32'(lvl0), 1);
    check("lat_busy_n", 32'(busy[0]), 1);
    check("lat_txd_n", 32'(txd[0]), 1);
    @(negedge clk);
    check("lat_level_n1", 32'(lvl0), 0);
    check("lat_txd_n1", 32'(txd[0]), 1);
    fork
      rx_frame(0, 8, 0, 1, 1'b1);
      begin
        bcnt = 0;
        while (busy[0] && bcnt < 1000) begin
          bcnt++;
          @(negedge clk);
        end
        check("busy_len", 32'(bcnt), 10 * CPB);
      end
    join
    @(negedge clk);
    check("idle_txd", 32'(txd[0]), 1);

    // 8E2: two queued words, stop exactly two bit times, then next start
    push(1, 9'h007, 1'b1);
    push(1, 9'h0A4, 1'b1);
    rx_frame(1, 8, 2, 2, 1'b0);
    rx_frame(1, 8, 2, 2, 1'b1);
    check("e2_busy_end", 32'(busy[1]), 0);

    // 5O1: odd parity, upper bits of the pushed value are dropped
    push(2, 9'h007, 1'b1);
    rx_frame(2, 5, 1, 1, 1'b0);
    push(2, 9'h1FF, 1'b1);
    rx_frame(2, 5, 1, 1, 1'b0);

    // Overflow: six consecutive pushes into depth 4, five contiguous frames
    fork
      begin
        for (int i = 0; i < 6; i++) push(0, ow[i], i < 5);
        check("ovf_pulse", 32'(ovf[0]), 1);
        check("ovf_level", 32'(lvl0), 4);
        check("ovf_ready", 32'(ready[0]), 0);
        @(negedge clk);
        check("ovf_clear", 32'(ovf[0]), 0);
      end
      begin
        rx_frame(0, 8, 0, 1, 1'b0);
        for (int i = 0; i < 4; i++) rx_frame(0, 8, 0, 1, 1'b1);
        check("burst_busy_end", 32'(busy[0]), 0);
        check("burst_sb_left", 32'(exp_q.size()), 0);
      end
    join

    // Reset mid-DATA with two words queued, then a clean frame
    push(0, 9'h011, 1'b1);
    push(0, 9'h022, 1'b1);
    push(0, 9'h033, 1'b1);
    repeat (40) @(negedge clk);
    check("pre_rst_level", 32'(lvl0), 2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_txd", 32'(txd[0]), 1);
    check("mid_rst_level", 32'(lvl0), 0);
    check("mid_rst_busy", 32'(busy[0]), 0);
    check("mid_rst_ready", 32'(ready[0]), 1);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    push(0, 9'h0C3, 1'b1);
    rx_frame(0, 8, 0, 1, 1'b0);
    check("final_sb_left", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
